// File: rtl/branch_stack_pkg.sv
// Shared types and sizes for the branch checkpoint stack: slot masks,
// map-table and free-list shapes, and the checkpoint packet itself.
package branch_stack_pkg;

   localparam int B_MASK_WIDTH      = 4;
   localparam int B_MASK_ID_BITS    = 2;
   localparam int PHYS_REG_SZ_R10K  = 64;
   localparam int PHYS_REG_IDX_BITS = 6;
   localparam int ARCH_REG_SZ_R10K  = 32;
   localparam int ROB_SZ_BITS       = 5;
   localparam int ADDR_BITS         = 32;

   typedef logic [B_MASK_WIDTH-1:0]      b_mask_t;
   typedef logic [PHYS_REG_IDX_BITS-1:0] phys_reg_idx_t;
   typedef logic [PHYS_REG_SZ_R10K-1:0]  free_list_t;
   typedef logic [ROB_SZ_BITS-1:0]       rob_idx_t;
   typedef logic [ADDR_BITS-1:0]         addr_t;
   typedef phys_reg_idx_t [ARCH_REG_SZ_R10K-1:0] map_table_t;

   // One checkpoint: the branches this one depends on, the rename state
   // to roll back to, and where fetch restarts.
   typedef struct packed {
      b_mask_t    b_m;
      map_table_t map_table;
      free_list_t free_list;
      rob_idx_t   rob_tail;
      addr_t      pc;
   } bs_entry_t;

endpackage

// File: rtl/branch_stack_if.sv
// Dispatch / resolve / recovery bundle between the pipeline and the
// branch stack. The stack itself takes the slave view.
interface branch_stack_if
   import branch_stack_pkg::*;
#(
   parameter int B_WIDTH = B_MASK_WIDTH,
   parameter int PR_SZ   = PHYS_REG_SZ_R10K
);
   bs_entry_t [B_WIDTH-1:0] branch_stack_entries;
   logic [B_WIDTH-1:0]      next_b_mask;
   logic                    resolve_valid;
   logic [B_WIDTH-1:0]      resolve_mask;
   logic                    resolve_mispredict;
   logic [PR_SZ-1:0]        freed_regs;
   logic [B_WIDTH-1:0]      b_mask_combinational;
   logic                    restore_valid;
   map_table_t              map_table_restore;
   logic [PR_SZ-1:0]        free_list_restore;
   rob_idx_t                rob_tail_restore;
   addr_t                   recovery_PC;
   logic [B_WIDTH-1:0]      squash_mask;
   logic [B_WIDTH-1:0]      clear_mask;

   modport master (
      output branch_stack_entries, next_b_mask, resolve_valid, resolve_mask,
             resolve_mispredict, freed_regs,
      input  b_mask_combinational, restore_valid, map_table_restore,
             free_list_restore, rob_tail_restore, recovery_PC, squash_mask,
             clear_mask
   );

   modport slave (
      input  branch_stack_entries, next_b_mask, resolve_valid, resolve_mask,
             resolve_mispredict, freed_regs,
      output b_mask_combinational, restore_valid, map_table_restore,
             free_list_restore, rob_tail_restore, recovery_PC, squash_mask,
             clear_mask
   );
endinterface

// File: rtl/branch_stack_encoder.sv
// One-hot to binary slot-index encoder. valid flags a nonzero input;
// with more than one bit set the highest set bit wins.
module branch_stack_encoder #(
   parameter int WIDTH   = 4,
   parameter int ID_BITS = 2
) (
   input  logic [WIDTH-1:0]   onehot,
   output logic [ID_BITS-1:0] idx,
   output logic               valid
);

   // Scan the mask and report the position of the set bit.
   always_comb begin
      idx   = {ID_BITS{1'b0}};
      valid = |onehot;
      for (int i = 0; i < WIDTH; i++) begin
         idx = onehot[i] ? ID_BITS'(i) : idx;
      end
   end

endmodule

// File: rtl/branch_stack.sv
// Branch checkpoint stack: holds one rename checkpoint per in-flight
// branch, answers resolutions with clear/squash masks, and on a
// mispredict presents the checkpoint in the same cycle.
module branch_stack
   import branch_stack_pkg::*;
#(
   parameter int B_WIDTH = B_MASK_WIDTH,
   parameter int PR_SZ   = PHYS_REG_SZ_R10K
) (
   input logic           clock,
   input logic           reset,
   branch_stack_if.slave bus
);

   bs_entry_t [B_WIDTH-1:0]   slot_r;
   bs_entry_t [B_WIDTH-1:0]   slot_nxt_s;
   logic [B_WIDTH-1:0]        b_mask_r;
   logic [B_WIDTH-1:0]        b_mask_nxt_s;
   logic [B_WIDTH-1:0]        squash_s;
   logic [B_WIDTH-1:0]        clear_s;
   logic [B_WIDTH-1:0]        live_s;
   logic [B_WIDTH-1:0]        write_s;
   logic [B_MASK_ID_BITS-1:0] res_idx_s;
   logic                      res_onehot_s;
   logic                      hit_s;
   logic                      restore_s;
   logic [PR_SZ-1:0]          freed_s;
   bs_entry_t                 restore_entry_s;
   logic [PR_SZ-1:0]          restore_free_s;

   assign freed_s = bus.freed_regs;

   branch_stack_encoder #(
      .WIDTH   (B_WIDTH),
      .ID_BITS (B_MASK_ID_BITS)
   ) u_res_enc (
      .onehot (bus.resolve_mask),
      .idx    (res_idx_s),
      .valid  (res_onehot_s)
   );

   // Classify this cycle's resolution and derive the clear/squash masks.
   // A resolution aimed at a dead slot is ignored entirely.
   always_comb begin
      hit_s     = bus.resolve_valid & res_onehot_s & (|(bus.resolve_mask & b_mask_r));
      restore_s = hit_s & bus.resolve_mispredict;
      if (hit_s && !bus.resolve_mispredict) begin
         clear_s = bus.resolve_mask;
      end else begin
         clear_s = {B_WIDTH{1'b0}};
      end
      if (restore_s) begin
         squash_s = bus.resolve_mask;
         for (int i = 0; i < B_WIDTH; i++) begin
            squash_s[i] = squash_s[i] | (b_mask_r[i] & slot_r[i].b_m[res_idx_s]);
         end
      end else begin
         squash_s = {B_WIDTH{1'b0}};
      end
      live_s = b_mask_r & ~squash_s & ~clear_s;
   end

   // Select the checkpoint to restore; retirement this cycle is folded
   // into the free list so nothing freed now is lost by the rollback.
   always_comb begin
      if (restore_s) begin
         restore_entry_s = slot_r[res_idx_s];
         restore_free_s  = restore_entry_s.free_list | freed_s;
      end else begin
         restore_entry_s = '{default: 1'b0};
         restore_free_s  = {PR_SZ{1'b0}};
      end
   end

   assign bus.b_mask_combinational = live_s;
   assign bus.restore_valid        = restore_s;
   assign bus.map_table_restore    = restore_entry_s.map_table;
   assign bus.free_list_restore    = restore_free_s;
   assign bus.rob_tail_restore     = restore_entry_s.rob_tail;
   assign bus.recovery_PC          = restore_entry_s.pc;
   assign bus.squash_mask          = squash_s;
   assign bus.clear_mask           = clear_s;

   // Next slot contents: allocate into freed slots (never during recovery),
   // otherwise keep live checkpoints current with resolves and retirement.
   always_comb begin
      slot_nxt_s = slot_r;
      write_s    = {B_WIDTH{1'b0}};
      for (int i = 0; i < B_WIDTH; i++) begin
         write_s[i] = ~restore_s & bus.next_b_mask[i] & ~live_s[i];
         if (write_s[i]) begin
            slot_nxt_s[i]           = bus.branch_stack_entries[i];
            slot_nxt_s[i].b_m       = bus.branch_stack_entries[i].b_m & ~clear_s;
            slot_nxt_s[i].free_list = bus.branch_stack_entries[i].free_list | freed_s;
         end else if (b_mask_r[i]) begin
            slot_nxt_s[i].b_m       = slot_r[i].b_m & ~clear_s;
            slot_nxt_s[i].free_list = slot_r[i].free_list | freed_s;
         end else begin
            slot_nxt_s[i] = slot_r[i];
         end
      end
      b_mask_nxt_s = restore_s ? live_s : bus.next_b_mask;
   end

   // Checkpoint storage and live mask; reset drops every checkpoint at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         b_mask_r <= {B_WIDTH{1'b0}};
         slot_r   <= '{default: '{default: 1'b0}};
      end else begin
         b_mask_r <= b_mask_nxt_s;
         slot_r   <= slot_nxt_s;
      end
   end

endmodule

// File: doc/branch_stack.md
BRANCH_STACK -- requirements
Module: branch_stack

Interface
REQ-001 SHALL have parameter B_WIDTH, default `B_MASK_WIDTH (4), meaning number of checkpoint slots.
REQ-002 SHALL have parameter PR_SZ, default `PHYS_REG_SZ_R10K, meaning free-list width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clock  input  1  rising-edge clock.
REQ-005 Port reset  input  1  asynchronous, active-low (asserted at 0).
REQ-006 Port branch_stack_entries  input  BS_ENTRY_PACKET[B_WIDTH]  checkpoints from dispatch, indexed by slot.
REQ-007 Port next_b_mask  input  B_MASK  dispatch's allocated-slot mask after this cycle's allocations.
REQ-008 Port resolve_valid  input  1  a branch resolves this cycle.
REQ-009 Port resolve_mask  input  B_MASK  one-hot slot of the resolving branch.
REQ-010 Port resolve_mispredict  input  1  resolved branch mispredicted.
REQ-011 Port freed_regs  input  PR_SZ  physical registers released by retirement this cycle (1 = freed).
REQ-012 Port b_mask_combinational  output  B_MASK  live slot mask after this cycle's resolution.
REQ-013 Port restore_valid  output  1  mispredict recovery this cycle.
REQ-014 Port map_table_restore  output  PHYS_REG_IDX[`ARCH_REG_SZ_R10K]  checkpointed map table.
REQ-015 Port free_list_restore  output  PR_SZ  checkpointed free list, retirement-corrected.
REQ-016 Port rob_tail_restore  output  `ROB_SZ_BITS  checkpointed ROB tail.
REQ-017 Port recovery_PC  output  ADDR  checkpointed recovery PC.
REQ-018 Port squash_mask  output  B_MASK  resolved slot plus all dependent slots on mispredict, else 0.
REQ-019 Port clear_mask  output  B_MASK  resolve_mask on correct prediction, else 0; broadcast to RS/ROB.

Function
REQ-020 b_mask_reg SHALL hold live slots; slot i live only if b_mask_reg[i]=1.
REQ-021 Resolution SHALL be ignored unless resolve_valid=1 and resolve_mask hits a live slot.
REQ-022 Correct resolve of slot k: b_mask_combinational = b_mask_reg & ~resolve_mask, same cycle (combinational); clear bit k of every stored b_m at the edge.
REQ-023 Mispredict of slot k: restore_valid=1 same cycle; restore outputs driven from slot k; squash_mask = {k} ∪ {i live : b_m[i][k]=1}; b_mask_combinational = b_mask_reg & ~squash_mask.
REQ-024 When restore_valid=0, restore data outputs SHALL be 0.
REQ-025 Slot i SHALL be written at the edge when next_b_mask[i]=1, b_mask_combinational[i]=0, restore_valid=0; stored b_m = entry b_m & ~clear_mask.
REQ-026 Next b_mask_reg = restore_valid ? b_mask_combinational : next_b_mask.
REQ-027 branch_stack_entries and next_b_mask SHALL be ignored while restore_valid=1.
REQ-028 Each edge: every live stored free_list |= freed_regs, including a slot written that edge.
REQ-029 free_list_restore SHALL equal stored free_list | freed_regs (same-cycle bypass).
REQ-030 Full (all slots live): no write occurs; resolution and retirement operate normally.
REQ-031 Correct resolve plus allocation into the slot freed that cycle SHALL be legal and store the new entry.
REQ-032 Latency: restore outputs zero-cycle; state updates visible next cycle.

Reset
REQ-033 While reset=0: b_mask_reg=0, all stored entries=0, all outputs 0.
REQ-034 Reset asserted mid-operation SHALL drop all checkpoints immediately; first post-reset cycle behaves as empty.

Structure
REQ-035 BS_ENTRY_PACKET, B_MASK, `B_MASK_WIDTH, `B_MASK_ID_BITS SHALL live in sys_defs.svh.
REQ-036 Slot index from resolve_mask SHALL use the shared encoder sub-module.
REQ-037 No other sub-modules; storage is a flat register array of B_WIDTH entries.

Verification
REQ-038 Reset, allocate slot 0 (next_b_mask=0001, PC=0x40) -> next cycle b_mask_combinational=0001.
REQ-039 Slots 0,1 live, slot 1 b_m=0001; mispredict slot 0 -> same cycle restore_valid=1, recovery_PC=0x40, squash_mask=0011, b_mask_combinational=0000.
REQ-040 Slots 0,1 live; correct resolve slot 0 -> clear_mask=0001, b_mask_combinational=0010; next cycle slot 1 b_m=0000.
REQ-041 Slot 2 free_list=0x0F; freed_regs bit 5 set; mispredict slot 2 next cycle -> free_list_restore=0x2F.
REQ-042 Full mask 1111, correct resolve slot 3 with next_b_mask=1111 and new entry in slot 3 -> slot 3 holds new entry, mask stays 1111.
REQ-043 Drive reset=0 asynchronously mid-cycle with 3 slots live -> outputs 0 immediately, mask 0000 after release.
